// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
// Shared definitions for the Viterbi decoder branch-metric path.
//   - default soft-bit and branch-metric widths
//   - sign-magnitude <-> two's-complement conversion helpers
//   - magnitude clamp helper
// Helpers work on a fixed 32-bit container so that callers of any width can
// share them; callers size-cast the results back to their own widths.
// -----------------------------------------------------------------------------
package viterbi_pkg;

    localparam int unsigned SOFT_W = 8;   // soft-bit width incl. sign
    localparam int unsigned BM_W   = 10;  // branch-metric width incl. sign
    localparam int unsigned MAX_W  = 32;  // container width for the helpers

    typedef logic signed [MAX_W-1:0] tc_t;
    typedef logic        [MAX_W-1:0] word_t;

    // Sign-magnitude value split into sign and unsigned magnitude.
    typedef struct packed {
        logic  neg;
        word_t mag;
    } sm_t;

    // Sign-magnitude (sign at bit w-1) to two's complement. -0 maps to 0.
    function automatic tc_t sm_to_tc(word_t sm, int unsigned w);
        word_t mag;
        logic  neg;
        mag = sm & ((word_t'(1) << (w - 1)) - word_t'(1));
        neg = ((sm >> (w - 1)) & word_t'(1)) != '0;
        return neg ? -tc_t'(mag) : tc_t'(mag);
    endfunction

    // Two's complement to sign/magnitude; a zero result always has sign 0.
    function automatic sm_t tc_to_sm(tc_t v);
        sm_t r;
        r.neg = v[MAX_W-1];
        r.mag = r.neg ? word_t'(-v) : word_t'(v);
        if (r.mag == '0) begin
            r.neg = 1'b0;
        end
        return r;
    endfunction

    // Clamp a magnitude to lim.
    function automatic word_t clamp(word_t mag, word_t lim);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/viterbi_bm_pipe_if.sv
// -----------------------------------------------------------------------------
// viterbi_bm_pipe_if
// Handshake and data bundle of the branch-metric pipeline.
//   in_valid/in_ready   : symbol pair transfer (r1_in, r2_in, sign-magnitude)
//   out_valid/out_ready : metric transfer (d1_out..d4_out, sat_out)
// Modports:
//   slave  : the branch-metric unit itself
//   master : the surrounding logic (demapper side + ACS side)
// -----------------------------------------------------------------------------
interface viterbi_bm_pipe_if
    import viterbi_pkg::*;
#(
    parameter int unsigned IW = SOFT_W,
    parameter int unsigned OW = BM_W
);

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] r1_in;
    logic [IW-1:0] r2_in;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] d1_out;
    logic [OW-1:0] d2_out;
    logic [OW-1:0] d3_out;
    logic [OW-1:0] d4_out;
    logic          sat_out;

    modport slave (
        input  in_valid, r1_in, r2_in, out_ready,
        output in_ready, out_valid, d1_out, d2_out, d3_out, d4_out, sat_out
    );

    modport master (
        output in_valid, r1_in, r2_in, out_ready,
        input  in_ready, out_valid, d1_out, d2_out, d3_out, d4_out, sat_out
    );

endinterface

// File: rtl/bm_sm_pack.sv
// -----------------------------------------------------------------------------
// bm_sm_pack
// Converts one two's-complement branch metric to saturated sign-magnitude.
//   metric_i : two's-complement metric, IW bits
//   sm_o     : sign-magnitude result, OW bits (sign at MSB), zero is always +0
//   clip_o   : magnitude exceeded 2^(OW-1)-1 and was clamped (sign kept)
// Purely combinational; the caller registers the result.
// -----------------------------------------------------------------------------
module bm_sm_pack
    import viterbi_pkg::*;
#(
    parameter int unsigned IW = 11,
    parameter int unsigned OW = 10
) (
    input  logic signed [IW-1:0] metric_i,
    output logic        [OW-1:0] sm_o,
    output logic                 clip_o
);

    localparam word_t MaxMag = (word_t'(1) << (OW - 1)) - word_t'(1);

    sm_t full;

    always_comb begin
        full   = tc_to_sm(tc_t'(metric_i));
        clip_o = full.mag > MaxMag;
        // A clamped magnitude is never zero, so canonical +0 survives the clamp.
        sm_o   = {full.neg, (OW - 1)'(clamp(full.mag, MaxMag))};
    end

endmodule

// File: rtl/viterbi_bm_pipe.sv
// -----------------------------------------------------------------------------
// viterbi_bm_pipe
// Two-stage elastic branch-metric unit for the rate-1/2 soft-decision Viterbi
// decoder. Accepts one sign-magnitude symbol pair per transfer and produces the
// four correlation metrics d1 = -(sR1+sR2), d2 = sR1+sR2, d3 = sR1-sR2,
// d4 = sR2-sR1 in saturated sign-magnitude.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : viterbi_bm_pipe_if slave (input pair handshake, metric handshake)
// Stage A: sign-magnitude -> scaled two's complement (registered).
// Stage B: sum/difference, negation, sign-magnitude packing (registered = outputs).
// -----------------------------------------------------------------------------
module viterbi_bm_pipe
    import viterbi_pkg::*;
#(
    parameter int unsigned IW    = SOFT_W,
    parameter int unsigned OW    = IW + 2,
    parameter int unsigned SHIFT = 1
) (
    input logic              clk,
    input logic              rst,
    viterbi_bm_pipe_if.slave bus
);

    localparam int unsigned AW = IW + SHIFT + 1;  // stage A width
    localparam int unsigned BW = AW + 1;          // stage B width, one bit of growth

    // Stage valids
    logic va_q, va_d;
    logic vb_q, vb_d;
    logic ld_a, ld_b;

    // Stage A data
    logic signed [AW-1:0] sa1_q, sa2_q;
    logic signed [AW-1:0] sa1_d, sa2_d;

    // Stage B datapath
    logic signed [BW-1:0] s_sum, t_diff;
    logic signed [BW-1:0] metric [4];
    logic        [OW-1:0] d_d    [4];
    logic        [OW-1:0] d_q    [4];
    logic        [3:0]    clip;
    logic                 sat_q;

    // A stage loads when it is empty or its contents move on this cycle.
    // ld_a equals !va || !vb || out_ready and never looks at in_valid.
    always_comb begin
        ld_b = !vb_q || bus.out_ready;
        ld_a = !va_q || ld_b;
    end

    always_comb begin
        va_d = va_q;
        vb_d = vb_q;
        if (ld_a) begin
            va_d = bus.in_valid;
        end
        if (ld_b) begin
            vb_d = va_q;
        end
    end

    // Stage A conversion: -0 collapses to 0 inside sm_to_tc.
    always_comb begin
        sa1_d = AW'(sm_to_tc(word_t'(bus.r1_in), IW) <<< SHIFT);
        sa2_d = AW'(sm_to_tc(word_t'(bus.r2_in), IW) <<< SHIFT);
    end

    // Stage B arithmetic on sign-extended operands.
    always_comb begin
        s_sum     = BW'(sa1_q) + BW'(sa2_q);
        t_diff    = BW'(sa1_q) - BW'(sa2_q);
        metric[0] = -s_sum;
        metric[1] = s_sum;
        metric[2] = t_diff;
        metric[3] = -t_diff;
    end

    for (genvar g = 0; g < 4; g++) begin : g_pack
        bm_sm_pack #(
            .IW (BW),
            .OW (OW)
        ) u_pack (
            .metric_i (metric[g]),
            .sm_o     (d_d[g]),
            .clip_o   (clip[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            va_q  <= 1'b0;
            vb_q  <= 1'b0;
            sa1_q <= '0;
            sa2_q <= '0;
            sat_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            va_q <= va_d;
            vb_q <= vb_d;
            if (ld_a && bus.in_valid) begin
                sa1_q <= sa1_d;
                sa2_q <= sa2_d;
            end
            // Outputs only change when a new beat enters stage B, so they
            // stay stable through a stall.
            if (ld_b && va_q) begin
                sat_q <= |clip;
                for (int i = 0; i < 4; i++) begin
                    d_q[i] <= d_d[i];
                end
            end
        end
    end

    assign bus.in_ready  = ld_a;
    assign bus.out_valid = vb_q;
    assign bus.d1_out    = d_q[0];
    assign bus.d2_out    = d_q[1];
    assign bus.d3_out    = d_q[2];
    assign bus.d4_out    = d_q[3];
    assign bus.sat_out   = sat_q;

endmodule

// File: tb/tb_viterbi_bm_pipe.sv
// -----------------------------------------------------------------------------
// tb_viterbi_bm_pipe
// Self-checking bench for viterbi_bm_pipe: fixed vector table, scoreboard
// queue filled on input transfer and drained on output transfer, plus
// hand-written backpressure, reset and OW=8 saturation sequences.
// -----------------------------------------------------------------------------
module tb_viterbi_bm_pipe;

    localparam int IW    = 8;
    localparam int OW    = 10;
    localparam int OW8   = 8;
    localparam int SHIFT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    viterbi_bm_pipe_if #(.IW(IW), .OW(OW))  bus  ();
    viterbi_bm_pipe_if #(.IW(IW), .OW(OW8)) bus8 ();

    viterbi_bm_pipe #(.IW(IW), .OW(OW), .SHIFT(SHIFT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    viterbi_bm_pipe #(.IW(IW), .OW(OW8), .SHIFT(SHIFT)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    typedef struct {
        logic [9:0] d1, d2, d3, d4;
        logic       sat;
    } exp_t;

    typedef struct {
        logic [7:0] r1, r2;
        exp_t       e;
    } vec_t;

    exp_t q [$];
    vec_t vecs [$];
    exp_t mon_e;
    exp_t e0;
    int   checks = 0;
    int   errors = 0;
    logic drv_done;
    logic [7:0] rr1, rr2;
    int   n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: integer arithmetic, then clamp to 9-bit magnitude.
    function automatic logic [10:0] to_sm(int v);
        int          m;
        logic [31:0] mb;
        logic [10:0] r;
        m     = (v < 0) ? -v : v;
        r[10] = m > 511;
        if (m > 511) m = 511;
        mb      = 32'(m);
        r[9]    = v < 0;
        r[8:0]  = mb[8:0];
        return r;
    endfunction

    function automatic exp_t model(logic [7:0] r1, logic [7:0] r2);
        int          a, b;
        logic [10:0] p1, p2, p3, p4;
        exp_t        e;
        a = int'(r1[6:0]) * (1 << SHIFT);
        b = int'(r2[6:0]) * (1 << SHIFT);
        if (r1[7]) a = -a;
        if (r2[7]) b = -b;
        p1 = to_sm(-(a + b));
        p2 = to_sm(a + b);
        p3 = to_sm(a - b);
        p4 = to_sm(b - a);
        e.d1  = p1[9:0];
        e.d2  = p2[9:0];
        e.d3  = p3[9:0];
        e.d4  = p4[9:0];
        e.sat = p1[10] | p2[10] | p3[10] | p4[10];
        return e;
    endfunction

    // Present one pair, wait (bounded) for acceptance, push its expectation.
    task automatic send(input logic [7:0] r1, input logic [7:0] r2, input exp_t e);
        bus.r1_in    = r1;
        bus.r2_in    = r2;
        bus.in_valid = 1'b1;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (k >= 50) begin
                chk("accept_timeout", 32'(bus.in_ready), 32'd1);
                @(posedge clk); #1;
                return;
            end
        end
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    // Scoreboard: compare on every output transfer.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'(bus.d2_out), 32'h0);
                if (bus.d2_out == '0) begin
                    errors++;
                    $display("FAIL unexpected_beat got beat want none at %0t", $time);
                end
            end else begin
                mon_e = q.pop_front();
                chk("d1", 32'(bus.d1_out), 32'(mon_e.d1));
                chk("d2", 32'(bus.d2_out), 32'(mon_e.d2));
                chk("d3", 32'(bus.d3_out), 32'(mon_e.d3));
                chk("d4", 32'(bus.d4_out), 32'(mon_e.d4));
                chk("sat", 32'(bus.sat_out), 32'(mon_e.sat));
            end
        end
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.r1_in      = '0;
        bus.r2_in      = '0;
        bus.out_ready  = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.r1_in     = '0;
        bus8.r2_in     = '0;
        bus8.out_ready = 1'b1;

        vecs.push_back('{8'h05, 8'h03, '{10'h210, 10'h010, 10'h004, 10'h204, 1'b0}});
        vecs.push_back('{8'h85, 8'h03, '{10'h004, 10'h204, 10'h210, 10'h010, 1'b0}});
        vecs.push_back('{8'h03, 8'h03, '{10'h20C, 10'h00C, 10'h000, 10'h000, 1'b0}});
        vecs.push_back('{8'h80, 8'h00, '{10'h000, 10'h000, 10'h000, 10'h000, 1'b0}});
        vecs.push_back('{8'h7F, 8'h7F, '{10'h3FC, 10'h1FC, 10'h000, 10'h000, 1'b0}});
        vecs.push_back('{8'hFF, 8'h7F, '{10'h000, 10'h000, 10'h3FC, 10'h1FC, 1'b0}});
        vecs.push_back('{8'h00, 8'h81, '{10'h002, 10'h202, 10'h002, 10'h202, 1'b0}});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_d1", 32'(bus.d1_out), 32'd0);
        chk("rst_d4", 32'(bus.d4_out), 32'd0);
        chk("rst_sat", 32'(bus.sat_out), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Table vectors, back to back
        @(posedge clk); #1;
        foreach (vecs[i]) send(vecs[i].r1, vecs[i].r2, vecs[i].e);
        bus.in_valid = 1'b0;
        wait_empty();

        // OW = 8 saturation
        @(posedge clk); #1;
        bus8.r1_in    = 8'h7F;
        bus8.r2_in    = 8'h7F;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus8.out_valid) break;
        end
        chk("ow8_valid", 32'(bus8.out_valid), 32'd1);
        chk("ow8_d2", 32'(bus8.d2_out), 32'h7F);
        chk("ow8_d1", 32'(bus8.d1_out), 32'hFF);
        chk("ow8_d3", 32'(bus8.d3_out), 32'h00);
        chk("ow8_d4", 32'(bus8.d4_out), 32'h00);
        chk("ow8_sat", 32'(bus8.sat_out), 32'd1);

        // Backpressure: 5 beats, out_ready low from cycle 3, then released
        @(posedge clk); #1;
        e0 = model(8'h10, 8'h83);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(8'(8'h10 + i), 8'(8'h83 + i), model(8'(8'h10 + i), 8'(8'h83 + i)));
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_d2_a", 32'(bus.d2_out), 32'(e0.d2));
                repeat (3) @(negedge clk);
                chk("stall_in_ready2", 32'(bus.in_ready), 32'd0);
                chk("stall_d1_b", 32'(bus.d1_out), 32'(e0.d1));
                chk("stall_d2_b", 32'(bus.d2_out), 32'(e0.d2));
                chk("stall_d3_b", 32'(bus.d3_out), 32'(e0.d3));
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("thruput_valid", 32'(bus.out_valid), 32'd1);
                end
            end
        join
        wait_empty();

        // Reset while both stages hold beats
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(8'h21, 8'h22, model(8'h21, 8'h22));
        send(8'h23, 8'h24, model(8'h23, 8'h24));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_d1", 32'(bus.d1_out), 32'd0);
        chk("mrst_d2", 32'(bus.d2_out), 32'd0);
        chk("mrst_d3", 32'(bus.d3_out), 32'd0);
        chk("mrst_d4", 32'(bus.d4_out), 32'd0);
        chk("mrst_sat", 32'(bus.sat_out), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        q.delete();
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mrst_idle", 32'(bus.out_valid), 32'd0);
        send(8'h05, 8'h03, model(8'h05, 8'h03));
        bus.in_valid = 1'b0;
        wait_empty();

        // Random pairs with random backpressure
        @(posedge clk); #1;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    rr1 = 8'($urandom);
                    rr2 = 8'($urandom);
                    send(rr1, rr2, model(rr1, rr2));
                end
                bus.in_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_empty();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
